// File: rtl/attn_pair_driver.sv
// attn_pair_driver: host-side transmitter for the attention-engine byte-pair stream.
// A loaded query vector is interleaved with streamed key vectors (q0,k0,q1,k1,...),
// one exp() result is collected per key and forwarded as a score beat, with
// score_last marking the final key of the query.
// Optional build macro ATTN_DRV_SUM_EN adds score_sum, the running sum of accepted
// results (softmax denominator), valid while score_vld & score_last.
module attn_pair_driver #(
   parameter int N_FEAT   = 4,
   parameter int N_KEYS   = 4,
   parameter int RES_SKIP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       q_vld,
   output logic       q_rdy,
   input  logic [7:0] q_data,
   input  logic       k_vld,
   output logic       k_rdy,
   input  logic [7:0] k_data,
   output logic       eng_vld,
   input  logic       eng_rdy,
   output logic [7:0] eng_data,
   input  logic       res_vld,
   output logic       res_rdy,
   input  logic [8:0] res_data,
   output logic       score_vld,
   input  logic       score_rdy,
   output logic [8:0] score_data,
   output logic       score_last,
   output logic       busy
`ifdef ATTN_DRV_SUM_EN
   ,
   output logic [8+$clog2(N_KEYS):0] score_sum
`endif
);

   localparam int FW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
   localparam int SW = (RES_SKIP > 0) ? $clog2(RES_SKIP + 1) : 1;

   localparam logic [2:0] ST_LOADQ   = 3'd0;
   localparam logic [2:0] ST_SEND    = 3'd1;
   localparam logic [2:0] ST_HOLDOFF = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_EMIT    = 3'd4;

   logic [2:0]    state_r;
   logic [FW-1:0] feat_idx_r;
   logic          phase_r;
   logic [KW-1:0] key_cnt_r;
   logic [SW-1:0] skip_cnt_r;
   logic [7:0]    q_mem_r [N_FEAT];
   logic          eng_hs_s;

   assign eng_hs_s = eng_vld & eng_rdy;

   // Handshake steering: query port in LOADQ, q/k byte mux in SEND, result port in WAIT.
   always_comb begin
      q_rdy    = 1'b0;
      k_rdy    = 1'b0;
      eng_vld  = 1'b0;
      eng_data = 8'h00;
      res_rdy  = 1'b0;
      case (state_r)
         ST_LOADQ: begin
            q_rdy = 1'b1;
         end
         ST_SEND: begin
            if (!phase_r) begin
               eng_vld  = 1'b1;
               eng_data = q_mem_r[feat_idx_r];
            end else begin
               // key bytes pass straight through; no key storage in this block
               eng_vld  = k_vld;
               eng_data = k_data;
               k_rdy    = eng_rdy;
            end
         end
         ST_WAIT: begin
            res_rdy = 1'b1;
         end
         default: begin
            q_rdy = 1'b0;
         end
      endcase
      busy = (state_r != ST_LOADQ);
   end

   // Control state machine, query store and registered score outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_LOADQ;
         feat_idx_r <= {FW{1'b0}};
         phase_r    <= 1'b0;
         key_cnt_r  <= {KW{1'b0}};
         skip_cnt_r <= {SW{1'b0}};
         score_vld  <= 1'b0;
         score_last <= 1'b0;
         score_data <= 9'h000;
         for (int i = 0; i < N_FEAT; i++) begin
            q_mem_r[i] <= 8'h00;
         end
      end else begin
         case (state_r)
            ST_LOADQ: begin
               if (q_vld) begin
                  q_mem_r[feat_idx_r] <= q_data;
                  if (feat_idx_r == FW'(N_FEAT - 1)) begin
                     feat_idx_r <= {FW{1'b0}};
                     phase_r    <= 1'b0;
                     key_cnt_r  <= {KW{1'b0}};
                     state_r    <= ST_SEND;
                  end else begin
                     feat_idx_r <= feat_idx_r + FW'(1);
                  end
               end else begin
                  state_r <= ST_LOADQ;
               end
            end
            ST_SEND: begin
               if (eng_hs_s) begin
                  phase_r <= ~phase_r;
                  if (phase_r) begin
                     if (feat_idx_r == FW'(N_FEAT - 1)) begin
                        feat_idx_r <= {FW{1'b0}};
                        skip_cnt_r <= SW'(RES_SKIP);
                        state_r    <= ST_HOLDOFF;
                     end else begin
                        feat_idx_r <= feat_idx_r + FW'(1);
                     end
                  end else begin
                     feat_idx_r <= feat_idx_r;
                  end
               end else begin
                  state_r <= ST_SEND;
               end
            end
            ST_HOLDOFF: begin
               // engine valid from the previous vector may still be high; ignore it
               if (skip_cnt_r <= SW'(1)) begin
                  skip_cnt_r <= {SW{1'b0}};
                  state_r    <= ST_WAIT;
               end else begin
                  skip_cnt_r <= skip_cnt_r - SW'(1);
               end
            end
            ST_WAIT: begin
               if (res_vld) begin
                  score_data <= res_data;
                  score_last <= (key_cnt_r == KW'(N_KEYS - 1));
                  score_vld  <= 1'b1;
                  state_r    <= ST_EMIT;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_EMIT: begin
               if (score_rdy) begin
                  score_vld <= 1'b0;
                  if (score_last) begin
                     state_r <= ST_LOADQ;
                  end else begin
                     key_cnt_r <= key_cnt_r + KW'(1);
                     state_r   <= ST_SEND;
                  end
               end else begin
                  state_r <= ST_EMIT;
               end
            end
            default: begin
               state_r <= ST_LOADQ;
            end
         endcase
      end
   end

`ifdef ATTN_DRV_SUM_EN
   localparam int SUMW = 9 + $clog2(N_KEYS);
   logic [SUMW-1:0] sum_r;

   // Softmax denominator: cleared while loading a query, adds each accepted result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r <= {SUMW{1'b0}};
      end else if (state_r == ST_LOADQ) begin
         sum_r <= {SUMW{1'b0}};
      end else if ((state_r == ST_WAIT) && res_vld) begin
         sum_r <= sum_r + SUMW'(res_data);
      end else begin
         sum_r <= sum_r;
      end
   end

   assign score_sum = sum_r;
`endif

endmodule
